// File: rtl/dot_matrix_pkg.sv
// Shared definitions for the 8x8 dot-matrix scan controller.
// Holds the scan FSM encoding, matrix geometry, drive polarities and
// small helpers that turn a row index / pixel byte into pin levels.
package dot_matrix_pkg;

    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 8;

    // Row select is active-high, column drive is active-low.
    localparam logic ROW_ON = 1'b1;
    localparam logic COL_ON = 1'b0;

    typedef enum logic {
        S_GAP = 1'b0,
        S_ROW = 1'b1
    } scan_state_e;

    // One-hot row select for a given row index.
    function automatic logic [ROWS-1:0] row_sel(input logic [2:0] row);
        row_sel      = {ROWS{~ROW_ON}};
        row_sel[row] = ROW_ON;
    endfunction

    // Column pin levels for a row of pixels (pixel bit i drives column i+1).
    function automatic logic [COLS-1:0] col_drive(input logic [COLS-1:0] pix);
        for (int i = 0; i < COLS; i++) begin
            col_drive[i] = pix[i] ? COL_ON : ~COL_ON;
        end
    endfunction

endpackage

// File: rtl/dot_scan_ctrl_if.sv
// Bus bundle for dot_scan_ctrl.
// master: frame-buffer writer / swap requester / blank source (drives
//         wr_en, wr_addr, wr_data, swap_req, blank; observes the rest).
// slave:  the scan controller (drives swap_ack, frame_start, dot_r, dot_c).
// dot_r/dot_c bit i corresponds to matrix line i+1.
interface dot_scan_ctrl_if;
    import dot_matrix_pkg::*;

    logic            wr_en;
    logic [2:0]      wr_addr;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic            blank;
    logic            frame_start;
    logic [ROWS-1:0] dot_r;
    logic [COLS-1:0] dot_c;

    modport master (
        output wr_en, wr_addr, wr_data, swap_req, blank,
        input  swap_ack, frame_start, dot_r, dot_c
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req, blank,
        output swap_ack, frame_start, dot_r, dot_c
    );

endinterface

// File: rtl/dot_fb_2x8x8.sv
// Double 8x8 frame buffer.
// Ports: clk_i/rst_ni clock and async active-low reset (clears both buffers);
//        wr_en_i/wr_addr_i/wr_data_i write one row into the back buffer, where
//        back is the buffer NOT selected by fsel_i at the writing edge;
//        rd_sel_i/rd_row_i -> rd_data_o combinational row read.
module dot_fb_2x8x8
    import dot_matrix_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_en_i,
    input  logic [2:0]      wr_addr_i,
    input  logic [COLS-1:0] wr_data_i,
    input  logic            fsel_i,
    input  logic            rd_sel_i,
    input  logic [2:0]      rd_row_i,
    output logic [COLS-1:0] rd_data_o
);

    logic [1:0][ROWS-1:0][COLS-1:0] mem_q, mem_d;

    // fsel_i is the pre-edge front select, so a write on a swap edge still
    // lands in the buffer that becomes front.
    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[~fsel_i][wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_o = mem_q[rd_sel_i][rd_row_i];

endmodule

// File: rtl/dot_scan_ctrl.sv
// 8x8 dot-matrix row-scan controller with double-buffered frame store.
// Each row is preceded by GAP all-off cycles and driven for DWELL cycles.
// Ports: clk, rstn (async active-low); bus (slave modport): wr_* write the
//        back buffer, swap_req/swap_ack swap front/back at the frame end,
//        blank darkens the outputs, frame_start marks row 0, dot_r one-hot
//        active-high row select, dot_c active-low column drive.
module dot_scan_ctrl
    import dot_matrix_pkg::*;
#(
    parameter int unsigned DWELL = 16,
    parameter int unsigned GAP   = 2
) (
    input logic             clk,
    input logic             rstn,
    dot_scan_ctrl_if.slave  bus
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] GAP_LAST   = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
    localparam scan_state_e RST_STATE  = (GAP == 0) ? S_ROW : S_GAP;
    // With no gap, the first edge after reset re-enters row 0 so that the
    // registered outputs and frame_start line up with a full row-0 dwell.
    localparam logic        FIRST_RST  = (GAP == 0);

    scan_state_e     state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            fsel_q, fsel_d;
    logic            first_q, first_d;
    logic [ROWS-1:0] dot_r_q, dot_r_d;
    logic [COLS-1:0] dot_c_q, dot_c_d;
    logic            swap_ack_q, swap_ack_d;
    logic            frame_start_q, frame_start_d;
    logic            enter_row;
    logic            lit;
    logic [COLS-1:0] fb_rd_data;

    dot_fb_2x8x8 u_fb (
        .clk_i     (clk),
        .rst_ni    (rstn),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .fsel_i    (fsel_q),
        .rd_sel_i  (fsel_d),
        .rd_row_i  (row_d),
        .rd_data_o (fb_rd_data)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        fsel_d     = fsel_q;
        first_d    = 1'b0;
        swap_ack_d = 1'b0;
        enter_row  = 1'b0;

        unique case (state_q)
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = S_ROW;
                    cnt_d     = '0;
                    enter_row = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ROW: begin
                if (first_q) begin
                    enter_row = 1'b1;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    row_d = row_q + 3'd1;
                    // Frame boundary: last dwell cycle of row 7.
                    if (row_q == 3'd7 && bus.swap_req) begin
                        fsel_d     = ~fsel_q;
                        swap_ack_d = 1'b1;
                    end
                    if (GAP == 0) begin
                        enter_row = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase

        frame_start_d = enter_row && (row_d == 3'd0);

        // Outputs are registered from next-state so they align with the state.
        lit     = (state_d == S_ROW) && !bus.blank;
        dot_r_d = lit ? row_sel(row_d) : {ROWS{~ROW_ON}};
        dot_c_d = lit ? col_drive(fb_rd_data) : {COLS{~COL_ON}};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= RST_STATE;
            row_q         <= '0;
            cnt_q         <= '0;
            fsel_q        <= 1'b0;
            first_q       <= FIRST_RST;
            dot_r_q       <= {ROWS{~ROW_ON}};
            dot_c_q       <= {COLS{~COL_ON}};
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            fsel_q        <= fsel_d;
            first_q       <= first_d;
            dot_r_q       <= dot_r_d;
            dot_c_q       <= dot_c_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.dot_r       = dot_r_q;
    assign bus.dot_c       = dot_c_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// Directed bench for dot_scan_ctrl: instance A (DWELL=4, GAP=1) and
// instance B (DWELL=1, GAP=0) share one clock with separate resets.
module tb_dot_scan_ctrl;

    logic clk = 1'b0;
    logic rstn_a, rstn_b;
    always #5 clk = ~clk;

    dot_scan_ctrl_if ifa ();
    dot_scan_ctrl_if ifb ();

    dot_scan_ctrl #(.DWELL(4), .GAP(1)) dut_a (.clk(clk), .rstn(rstn_a), .bus(ifa));
    dot_scan_ctrl #(.DWELL(1), .GAP(0)) dut_b (.clk(clk), .rstn(rstn_b), .bus(ifb));

    int n_cmp = 0;
    int n_err = 0;

    // Model of instance A: row period 5 (1 gap + 4 dwell), frame period 40.
    // t_a = 0 is the first cycle after the first edge following release.
    int         t_a;
    logic [7:0] mbuf [0:1][0:7];
    logic       mfsel;
    logic       exp_ack;
    logic       exp_blank;

    function automatic logic [7:0] exp_r_a(int t, logic blk);
        logic [7:0] v;
        logic [2:0] row;
        v = 8'h00;
        row = 3'((t / 5) % 8);
        if (t >= 0 && !blk && (t % 5) != 4) v = 8'h01 << row;
        return v;
    endfunction

    function automatic logic [7:0] exp_c_a(int t, logic blk);
        logic [7:0] v;
        logic [2:0] row;
        v = 8'hFF;
        row = 3'((t / 5) % 8);
        if (t >= 0 && !blk && (t % 5) != 4) v = ~mbuf[mfsel][row];
        return v;
    endfunction

    function automatic logic exp_fs_a(int t);
        return (t >= 0) && (t % 40 == 0);
    endfunction

    // Advance instance A by one clock, updating the model for that edge.
    task automatic step_a();
        if (ifa.wr_en) mbuf[!mfsel][ifa.wr_addr] = ifa.wr_data;
        exp_ack = 1'b0;
        if (t_a >= 0 && t_a % 40 == 38 && ifa.swap_req) begin
            mfsel   = ~mfsel;
            exp_ack = 1'b1;
        end
        exp_blank = ifa.blank;
        @(negedge clk);
        t_a++;
    endtask

    task automatic reset_model_a();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) mbuf[b][r] = 8'h00;
        mfsel     = 1'b0;
        exp_ack   = 1'b0;
        exp_blank = 1'b0;
        t_a       = -1;
    endtask

    task automatic test_reset();
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ifa.dot_r !== 8'h00) begin n_err++;
            $display("FAIL reset_a_dot_r got=%h exp=00", ifa.dot_r); end
        n_cmp++; if (ifa.dot_c !== 8'hFF) begin n_err++;
            $display("FAIL reset_a_dot_c got=%h exp=FF", ifa.dot_c); end
        n_cmp++; if (ifa.swap_ack !== 1'b0) begin n_err++;
            $display("FAIL reset_a_swap_ack got=%b exp=0", ifa.swap_ack); end
        n_cmp++; if (ifa.frame_start !== 1'b0) begin n_err++;
            $display("FAIL reset_a_frame_start got=%b exp=0", ifa.frame_start); end
        n_cmp++; if (ifb.dot_r !== 8'h00 || ifb.dot_c !== 8'hFF) begin n_err++;
            $display("FAIL reset_b_dots got=%h/%h exp=00/FF", ifb.dot_r, ifb.dot_c); end
        rstn_a = 1'b1;
        reset_model_a();
    endtask

    task automatic test_scan();
        for (int i = 0; i < 80; i++) begin
            step_a();
            n_cmp++; if (ifa.dot_r !== exp_r_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL scan_dot_r t=%0d got=%h exp=%h", t_a, ifa.dot_r,
                         exp_r_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.dot_c !== 8'hFF) begin n_err++;
                $display("FAIL scan_dot_c t=%0d got=%h exp=FF", t_a, ifa.dot_c); end
            n_cmp++; if (ifa.frame_start !== exp_fs_a(t_a)) begin n_err++;
                $display("FAIL scan_frame_start t=%0d got=%b exp=%b", t_a,
                         ifa.frame_start, exp_fs_a(t_a)); end
        end
    endtask

    task automatic test_swap();
        ifa.wr_en   = 1'b1;
        ifa.wr_addr = 3'd3;
        ifa.wr_data = 8'hA5;
        step_a();
        ifa.wr_en    = 1'b0;
        ifa.swap_req = 1'b1;
        for (int i = 0; i < 90; i++) begin
            step_a();
            if (exp_ack) ifa.swap_req = 1'b0;
            n_cmp++; if (ifa.dot_r !== exp_r_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL swap_dot_r t=%0d got=%h exp=%h", t_a, ifa.dot_r,
                         exp_r_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.dot_c !== exp_c_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL swap_dot_c t=%0d got=%h exp=%h", t_a, ifa.dot_c,
                         exp_c_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.swap_ack !== exp_ack) begin n_err++;
                $display("FAIL swap_ack t=%0d got=%b exp=%b", t_a, ifa.swap_ack, exp_ack); end
        end
    endtask

    // Write row 0 exactly on a swap edge, hold swap_req across two frames,
    // then drop it and confirm no further swap.
    task automatic test_swap_edge_write();
        logic wrote;
        wrote = 1'b0;
        ifa.swap_req = 1'b1;
        for (int i = 0; i < 145; i++) begin
            if (t_a % 40 == 38 && !wrote) begin
                ifa.wr_en   = 1'b1;
                ifa.wr_addr = 3'd0;
                ifa.wr_data = 8'hFF;
                wrote = 1'b1;
            end
            if (i == 100) ifa.swap_req = 1'b0;
            step_a();
            ifa.wr_en = 1'b0;
            n_cmp++; if (ifa.dot_r !== exp_r_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL edge_dot_r t=%0d got=%h exp=%h", t_a, ifa.dot_r,
                         exp_r_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.dot_c !== exp_c_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL edge_dot_c t=%0d got=%h exp=%h", t_a, ifa.dot_c,
                         exp_c_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.swap_ack !== exp_ack) begin n_err++;
                $display("FAIL edge_swap_ack t=%0d got=%b exp=%b", t_a, ifa.swap_ack, exp_ack); end
            n_cmp++; if (ifa.frame_start !== exp_fs_a(t_a)) begin n_err++;
                $display("FAIL edge_frame_start t=%0d got=%b exp=%b", t_a,
                         ifa.frame_start, exp_fs_a(t_a)); end
        end
    endtask

    // Three dark cycles inside row 2, drive resumes on its last dwell cycle.
    task automatic test_blank();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (t_a % 40 == 9 && !done) ifa.blank = 1'b1;
            if (t_a % 40 == 12 && ifa.blank) begin
                ifa.blank = 1'b0;
                done = 1'b1;
            end
            step_a();
            n_cmp++; if (ifa.dot_r !== exp_r_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL blank_dot_r t=%0d got=%h exp=%h", t_a, ifa.dot_r,
                         exp_r_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.dot_c !== exp_c_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL blank_dot_c t=%0d got=%h exp=%h", t_a, ifa.dot_c,
                         exp_c_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.frame_start !== exp_fs_a(t_a)) begin n_err++;
                $display("FAIL blank_frame_start t=%0d got=%b exp=%b", t_a,
                         ifa.frame_start, exp_fs_a(t_a)); end
        end
    endtask

    // Reset during row 5 with a swap pending: immediate dark, buffers cleared.
    task automatic test_reset_midframe();
        for (int i = 0; i < 45 && (t_a % 40) != 26; i++) step_a();
        ifa.swap_req = 1'b1;
        #2;
        rstn_a = 1'b0;
        #1;
        n_cmp++; if (ifa.dot_r !== 8'h00 || ifa.dot_c !== 8'hFF) begin n_err++;
            $display("FAIL midrst_async_dots got=%h/%h exp=00/FF", ifa.dot_r, ifa.dot_c); end
        n_cmp++; if (ifa.swap_ack !== 1'b0) begin n_err++;
            $display("FAIL midrst_async_ack got=%b exp=0", ifa.swap_ack); end
        @(negedge clk);
        ifa.swap_req = 1'b0;
        rstn_a = 1'b1;
        reset_model_a();
        for (int i = 0; i < 45; i++) begin
            step_a();
            n_cmp++; if (ifa.dot_r !== exp_r_a(t_a, exp_blank)) begin n_err++;
                $display("FAIL midrst_dot_r t=%0d got=%h exp=%h", t_a, ifa.dot_r,
                         exp_r_a(t_a, exp_blank)); end
            n_cmp++; if (ifa.dot_c !== 8'hFF) begin n_err++;
                $display("FAIL midrst_dot_c t=%0d got=%h exp=FF", t_a, ifa.dot_c); end
            n_cmp++; if (ifa.swap_ack !== 1'b0) begin n_err++;
                $display("FAIL midrst_swap_ack t=%0d got=%b exp=0", t_a, ifa.swap_ack); end
        end
    endtask

    // GAP=0, DWELL=1: one row per cycle, plus a swap showing on row 0 at once.
    task automatic test_gap0();
        int         t_b;
        logic [2:0] row;
        logic [7:0] er, ec;
        logic       efs, eack;
        rstn_b = 1'b0;
        @(negedge clk);
        rstn_b = 1'b1;
        t_b = -1;
        n_cmp++; if (ifb.dot_r !== 8'h00 || ifb.frame_start !== 1'b0) begin n_err++;
            $display("FAIL gap0_release got=%h/%b exp=00/0", ifb.dot_r, ifb.frame_start); end
        for (int i = 0; i < 48; i++) begin
            ifb.wr_en    = (t_b == 23);
            ifb.wr_addr  = 3'd0;
            ifb.wr_data  = 8'h81;
            ifb.swap_req = (t_b == 31);
            @(negedge clk);
            t_b++;
            row  = 3'(t_b % 8);
            er   = 8'h01 << row;
            efs  = (row == 3'd0);
            ec   = (t_b >= 32 && row == 3'd0) ? 8'h7E : 8'hFF;
            eack = (t_b == 32);
            n_cmp++; if (ifb.dot_r !== er) begin n_err++;
                $display("FAIL gap0_dot_r t=%0d got=%h exp=%h", t_b, ifb.dot_r, er); end
            n_cmp++; if (ifb.dot_c !== ec) begin n_err++;
                $display("FAIL gap0_dot_c t=%0d got=%h exp=%h", t_b, ifb.dot_c, ec); end
            n_cmp++; if (ifb.frame_start !== efs) begin n_err++;
                $display("FAIL gap0_frame_start t=%0d got=%b exp=%b", t_b, ifb.frame_start,
                         efs); end
            n_cmp++; if (ifb.swap_ack !== eack) begin n_err++;
                $display("FAIL gap0_swap_ack t=%0d got=%b exp=%b", t_b, ifb.swap_ack, eack); end
        end
        ifb.wr_en    = 1'b0;
        ifb.swap_req = 1'b0;
    endtask

    initial begin
        ifa.wr_en = 1'b0; ifa.wr_addr = 3'd0; ifa.wr_data = 8'h00;
        ifa.swap_req = 1'b0; ifa.blank = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_addr = 3'd0; ifb.wr_data = 8'h00;
        ifb.swap_req = 1'b0; ifb.blank = 1'b0;
        reset_model_a();
        test_reset();
        test_scan();
        test_swap();
        test_swap_edge_write();
        test_blank();
        test_reset_midframe();
        test_gap0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
